// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: moves a 32-bit operand one bit per cycle under a
// valid/ready handshake. Define SEQ_SHIFTER_ROTATE_EN to turn Shiftop=01 into rotate-right.
module seq_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [4:0]  B,
  input  logic [1:0]  Shiftop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  state_e      state_q;
  logic [31:0] w_q;
  logic [31:0] w_d;
  logic [31:0] load_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  function automatic logic [31:0] shift_step(input logic [31:0] w, input logic [1:0] op);
    case (op)
      OP_SLL:  return {w[30:0], 1'b0};
      OP_SRL:  return {1'b0, w[31:1]};
      OP_SRA:  return {w[31], w[31:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROTR: return {w[0], w[31:1]};
`endif
      default: return '0;
    endcase
  endfunction

  assign w_d = shift_step(w_q, op_q);

`ifdef SEQ_SHIFTER_ROTATE_EN
  assign load_d = A;
`else
  // Reserved op loads zero so Result is 0 even when B==0 skips the shift phase.
  assign load_d = (Shiftop == OP_ROTR) ? 32'h0 : A;
`endif

  // NOTE: non-blocking assignments throughout; every register here is sampled by
  // other branches in the same edge, so blocking updates would create ordering bugs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      cnt_q       <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            w_q        <= load_d;
            cnt_q      <= B;
            op_q       <= Shiftop;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (B == 5'd0) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          w_q   <= w_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign Result    = w_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: arithmetic reference model with per-cycle
// comparison plus directed operations with hand-computed results and latencies.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [4:0]  B = '0;
  logic [1:0]  Shiftop = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_shifter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Shiftop  (Shiftop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference result straight from the operation's arithmetic definition.
  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [4:0] b,
                                               input logic [1:0] op);
    logic [63:0] dbl;
    case (op)
      2'b00: return a << b;
      2'b10: return a >> b;
      2'b11: return 32'($signed(a) >>> b);
      default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        dbl = {a, a} >> b;
        return dbl[31:0];
`else
        dbl = '0;
        return dbl[31:0];
`endif
      end
    endcase
  endfunction

  // Model: one outstanding operation, result visible from edge (accept + B) until handshake.
  int          edge_n = 0;
  int          m_from = 0;
  bit          m_out = 1'b0;
  logic [31:0] m_exp = '0;
  bit          cmp_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 1'b0;
    end else begin
      edge_n++;
      if (!m_out) begin
        if (in_valid) begin
          m_out  = 1'b1;
          m_from = edge_n + int'(B);
          m_exp  = model_result(A, B, Shiftop);
        end
      end else if ((edge_n - 1 >= m_from) && out_ready) begin
        m_out = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!rst_n) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", Result, 32'h0);
      end else begin
        check("cyc_in_ready", 32'(in_ready), 32'(!m_out));
        check("cyc_busy", 32'(busy), 32'(m_out));
        check("cyc_out_valid", 32'(out_valid), 32'(m_out && (edge_n >= m_from)));
        if (m_out && (edge_n >= m_from))
          check("cyc_result", Result, m_exp);
      end
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] op, input logic [31:0] exp, input int stall,
                        input bit hold_valid);
    int k;
    @(negedge clk);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    Shiftop   = op;
    out_ready = 1'b0;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    A       = $urandom;
    B       = 5'($urandom);
    Shiftop = 2'($urandom);
    k = 1;
    while (!out_valid && k <= 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'(b) + 32'd1);
    check({name, "_result"}, Result, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({name, "_stall_result"}, Result, exp);
      check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({name, "_back_idle"}, 32'(in_ready), 32'd1);
    check({name, "_ov_cleared"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #2;
    check("reset_result", Result, 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("reset_release_ready", 32'(in_ready), 32'd1);

    run_op("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 0, 1'b0);
    run_op("sra4", 32'h8000_0000, 5'd4, 2'b11, 32'hF800_0000, 0, 1'b0);
    run_op("srl4", 32'h8000_0000, 5'd4, 2'b10, 32'h0800_0000, 0, 1'b0);
    run_op("sll0", 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678, 0, 1'b0);
    run_op("srl0", 32'h1234_5678, 5'd0, 2'b10, 32'h1234_5678, 0, 1'b0);
    run_op("sra0", 32'h1234_5678, 5'd0, 2'b11, 32'h1234_5678, 0, 1'b0);
    run_op("sra8pos", 32'h7FFF_FFF0, 5'd8, 2'b11, 32'h007F_FFFF, 0, 1'b0);
    run_op("sll16", 32'hDEAD_BEEF, 5'd16, 2'b00, 32'hBEEF_0000, 0, 1'b0);
    run_op("stall", 32'h0000_00F0, 5'd3, 2'b00, 32'h0000_0780, 10, 1'b1);
    run_op("after_stall", 32'hF000_0000, 5'd1, 2'b11, 32'hF800_0000, 0, 1'b0);
`ifdef SEQ_SHIFTER_ROTATE_EN
    run_op("rotr4", 32'h0000_000F, 5'd4, 2'b01, 32'hF000_0000, 0, 1'b0);
    run_op("rotr0", 32'h1234_5678, 5'd0, 2'b01, 32'h1234_5678, 0, 1'b0);
`else
    run_op("rsvd4", 32'h0000_000F, 5'd4, 2'b01, 32'h0000_0000, 0, 1'b0);
    run_op("rsvd0", 32'h1234_5678, 5'd0, 2'b01, 32'h0000_0000, 0, 1'b0);
`endif

    // Abort an SLL B=20 mid-shift with an asynchronous reset pulse.
    @(negedge clk);
    in_valid = 1'b1;
    A        = 32'h0000_0001;
    B        = 5'd20;
    Shiftop  = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", Result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_release_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_output", 32'(seen), 32'd0);

    run_op("post_abort", 32'h0000_0003, 5'd2, 2'b00, 32'h0000_000C, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operand set on A/B/Shiftop is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-005 SHALL have port A, input, 32 bits: operand to shift.
REQ-006 SHALL have port B, input, 5 bits: shift amount, 0..31.
REQ-007 SHALL have port Shiftop, input, 2 bits: 00 SLL, 10 SRL, 11 SRA, 01 reserved/ROTR.
REQ-008 SHALL have port out_valid, output, 1 bit: Result holds a completed operation.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts Result.
REQ-010 SHALL have port Result, output, 32 bits: shifted value.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE (one-hot or binary, implementer's choice).
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 SHALL accept on the edge where in_valid&in_ready, capturing A into a 32-bit working register, B into a 5-bit down-counter, Shiftop into an op register; later input changes are ignored.
REQ-015 SHALL go IDLE->DONE on accept when B==0, else IDLE->SHIFT.
REQ-016 SHALL in SHIFT move the working register one bit per cycle and decrement the counter, going to DONE on the cycle the counter reaches 0; exactly B shift cycles.
REQ-017 SHALL make out_valid rise exactly B+1 cycles after the accept edge (B==0: next cycle).
REQ-018 SHALL do per step: SLL {w[30:0],0}; SRL {0,w[31:1]}; SRA {w[31],w[31:1]}.
REQ-019 SHALL hold Result and out_valid stable in DONE until out_valid&out_ready, then go DONE->IDLE; no accept in that same cycle.
REQ-020 SHALL drive Result from the working register at all times; value is only defined while out_valid=1.
REQ-021 SHALL with Shiftop=01 and ROTATE_EN undefined complete normally with Result=32'h0 and the same latency.
REQ-022 SHALL ignore in_valid outside IDLE, so no operation is lost or queued.

Reset
REQ-023 SHALL on rst_n=0, at any time including mid-SHIFT or in DONE, force IDLE, working register=0, counter=0, op=00, out_valid=0, busy=0, Result=0.
REQ-024 SHALL drive in_ready=1 in the first cycle after rst_n deasserts; an aborted operation produces no output.

Configuration
REQ-025 SHALL, when macro SEQ_SHIFTER_ROTATE_EN is defined, treat Shiftop=01 as rotate right, step {w[0],w[31:1]}, same latency rule.
REQ-026 SHALL, when SEQ_SHIFTER_ROTATE_EN is undefined, contain no rotate logic and behave per REQ-021.

Verification
REQ-027 SHALL cover: SLL, A=32'h0000_0001, B=31 -> Result=32'h8000_0000, out_valid 32 cycles after accept.
REQ-028 SHALL cover: SRA A=32'h8000_0000 B=4 -> 32'hF800_0000; SRL same operands -> 32'h0800_0000; both after 5 cycles.
REQ-029 SHALL cover: B=0, A=32'h1234_5678, each op -> Result=32'h1234_5678, out_valid the cycle after accept.
REQ-030 SHALL cover: out_ready low 10 cycles in DONE with in_valid held high -> Result stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle, then accept.
REQ-031 SHALL cover: rst_n pulsed low during SHIFT of SLL B=20 -> outputs zero immediately, in_ready=1 after release, no out_valid.
REQ-032 SHALL cover: Shiftop=01, A=32'h0000_000F, B=4 -> 32'hF000_0000 with SEQ_SHIFTER_ROTATE_EN, 32'h0 without.
